// File: rtl/multi_stream_controller.sv
// multi_stream_controller: loads a config block, fills instruction memory, then runs the MVP core
// servicing trapped multi-channel I/O and matrix-offload requests.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   params_fifo_dout/empty_n/deq     config byte stream (low byte of dout used)
//   instr_wen/full_n/wadr            instruction memory fill
//   input_wen/full_n/wadr            per-channel input streams (packed, ch0 in LSBs)
//   output_wb_ren/empty_n/wb_radr    per-channel output streams (packed, ch0 in LSBs)
//   mem_addr/mem_read/mem_write      core access trap
//   mvp_core_en                      registered core run enable
//   offload_start/busy/done          matrix offload handshake
//   iter_count, done, state_r        status and debug state
module multi_stream_controller #(
    parameter int INPUT_FIFO_WIDTH     = 16,
    parameter int ADDR_WIDTH           = 16,
    parameter int INSTR_MEM_ADDR_WIDTH = 8,
    parameter int DATA_MEM_ADDR_WIDTH  = 12,
    parameter int NUM_IN_CH            = 2,
    parameter int NUM_OUT_CH           = 2,
    parameter int CONFIG_DATA_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] OFFLOAD_ADDR = 16'h2000
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [INPUT_FIFO_WIDTH-1:0]               params_fifo_dout,
    input  logic                                      params_fifo_empty_n,
    output logic                                      params_fifo_deq,
    input  logic                                      instr_wen,
    output logic                                      instr_full_n,
    output logic [INSTR_MEM_ADDR_WIDTH-1:0]           instr_wadr,
    input  logic [NUM_IN_CH-1:0]                      input_wen,
    output logic [NUM_IN_CH-1:0]                      input_full_n,
    output logic [NUM_IN_CH*DATA_MEM_ADDR_WIDTH-1:0]  input_wadr,
    input  logic [NUM_OUT_CH-1:0]                     output_wb_ren,
    output logic [NUM_OUT_CH-1:0]                     output_empty_n,
    output logic [NUM_OUT_CH*DATA_MEM_ADDR_WIDTH-1:0] output_wb_radr,
    input  logic [ADDR_WIDTH-1:0]                     mem_addr,
    input  logic                                      mem_read,
    input  logic                                      mem_write,
    output logic                                      mvp_core_en,
    output logic                                      offload_start,
    output logic                                      offload_busy,
    input  logic                                      offload_done,
    output logic [15:0]                               iter_count,
    output logic                                      done,
    output logic [2:0]                                state_r
);
    localparam int NUM_CONFIGS = 4 + 4 * (NUM_IN_CH + NUM_OUT_CH);
    localparam int CW  = CONFIG_DATA_WIDTH;
    localparam int FW  = 2 * CW;
    localparam int DW  = DATA_MEM_ADDR_WIDTH;
    localparam int IW  = INSTR_MEM_ADDR_WIDTH;
    localparam int CAW = $clog2(NUM_CONFIGS);

    typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, RUN = 3'd2, IO = 3'd3, OFFLOAD = 3'd4, DONE = 3'd5} state_t;
    state_t state, next_state;

    logic [NUM_CONFIGS*CW-1:0] cfg;
    logic [CAW-1:0]            cfg_adr;
    logic [IW:0]               instr_adr;
    logic [NUM_IN_CH-1:0]      in_fin;
    logic [NUM_OUT_CH-1:0]     out_fin;
    logic                      io_req, off_req, all_fin;

    // Config words are little-endian byte pairs; word k sits at bit k*FW.
    wire [FW-1:0] instr_max  = cfg[0 +: FW];
    wire [FW-1:0] iter_limit = cfg[(1 + 2 * (NUM_IN_CH + NUM_OUT_CH)) * FW +: FW];
    wire [DW-1:0] in_off0    = cfg[2 * FW +: DW];
    wire [IW:0]   instr_last = {1'b0, instr_max[IW-1:0]};

    // Config fields wider than the address spaces and the upper FIFO bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{cfg, params_fifo_dout};

    assign state_r    = state;
    assign instr_wadr = instr_adr[IW-1:0];
    assign io_req     = mem_read && mem_addr == ADDR_WIDTH'(in_off0);
    assign off_req    = mem_write && mem_addr == OFFLOAD_ADDR;
    assign all_fin    = &in_fin && &out_fin;

    // Counters are one bit wider than the address so off+max+1 never wraps.
    for (genvar i = 0; i < NUM_IN_CH; i++) begin : g_in
        wire [DW-1:0] off  = cfg[(2 + 2 * i) * FW +: DW];
        wire [DW-1:0] mx   = cfg[(1 + 2 * i) * FW +: DW];
        wire [DW:0]   last = {1'b0, off} + {1'b0, mx};
        logic [DW:0]  adr;
        assign input_full_n[i]          = state == IO && adr <= last;
        assign in_fin[i]                = adr > last;
        assign input_wadr[i*DW +: DW]   = adr[DW-1:0];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) adr <= '0;
            else if (state == RUN && next_state == IO) adr <= {1'b0, off};
            else if (input_wen[i] && input_full_n[i]) adr <= adr + 1'b1;
    end

    for (genvar j = 0; j < NUM_OUT_CH; j++) begin : g_out
        wire [DW-1:0] off  = cfg[(2 + 2 * NUM_IN_CH + 2 * j) * FW +: DW];
        wire [DW-1:0] mx   = cfg[(1 + 2 * NUM_IN_CH + 2 * j) * FW +: DW];
        wire [DW:0]   last = {1'b0, off} + {1'b0, mx};
        logic [DW:0]  adr;
        assign output_empty_n[j]          = state == IO && adr <= last;
        assign out_fin[j]                 = adr > last;
        assign output_wb_radr[j*DW +: DW] = adr[DW-1:0];
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) adr <= '0;
            else if (state == RUN && next_state == IO) adr <= {1'b0, off};
            else if (output_wb_ren[j] && output_empty_n[j]) adr <= adr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;

    // IO is checked before offload so a simultaneous offload request is dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (params_fifo_deq && cfg_adr == CAW'(NUM_CONFIGS - 1)) next_state = FILL;
            FILL:    if (instr_adr == instr_last + 1'b1) next_state = RUN;
            RUN:     next_state = io_req ? IO : off_req ? OFFLOAD : RUN;
            IO:      if (all_fin) next_state = (iter_limit != '0 && iter_count + 16'd1 == 16'(iter_limit)) ? DONE : RUN;
            OFFLOAD: if (offload_done) next_state = RUN;
            DONE:    if (params_fifo_empty_n) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        params_fifo_deq = params_fifo_empty_n && state == IDLE;
        instr_full_n    = state == FILL && instr_adr <= instr_last;
        offload_busy    = state == OFFLOAD;
        done            = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cfg           <= '0;
            cfg_adr       <= '0;
            instr_adr     <= '0;
            iter_count    <= '0;
            mvp_core_en   <= 1'b0;
            offload_start <= 1'b0;
        end else begin
            mvp_core_en   <= next_state == RUN;
            offload_start <= state == RUN && next_state == OFFLOAD;
            if (params_fifo_deq) begin
                cfg[cfg_adr*CW +: CW] <= params_fifo_dout[CW-1:0];
                cfg_adr <= cfg_adr == CAW'(NUM_CONFIGS - 1) ? '0 : cfg_adr + 1'b1;
            end
            if (state == IDLE && next_state == FILL) instr_adr <= '0;
            else if (instr_wen && instr_full_n) instr_adr <= instr_adr + 1'b1;
            if (state == DONE && next_state == IDLE) iter_count <= '0;
            else if (state == IO && next_state != IO) iter_count <= iter_count + 16'd1;
        end
endmodule
